// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between the request channels, the round-robin scheduler
// and the downstream 8:1 byte mux / sink.
interface mux_rr_sched_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic [N_CH-1:0]   req_valid;
    logic [DATA_W-1:0] req_data [0:N_CH-1];
    logic [N_CH-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;

    // Producer side: drives the channel requests and the downstream ready.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler with a per-channel burst allowance. The winning byte
// and its channel index are registered together so the mux stage and the sink
// always see a matching select/data pair.
module mux_rr_sched #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int BURST  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_rr_sched_if.slave bus
);
    logic [SEL_W-1:0]  r_ptr;
    logic [3:0]        r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    logic              w_load;
    logic              w_any;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_grant;
    logic [3:0]        w_base;
    logic [3:0]        w_next_cnt;

    // The output register may refill in the same cycle it drains.
    assign w_load     = !r_out_valid || bus.out_ready;
    assign w_any      = |bus.req_valid;
    assign w_xfer     = w_load && w_any;
    assign w_base     = (w_grant == r_ptr) ? r_cnt : 4'd0;
    assign w_next_cnt = w_base + 4'd1;

    // Search from ptr upward with wrap; the nearest requester wins.
    always_comb begin
        w_grant = r_ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.req_valid[r_ptr + SEL_W'(k)]) begin
                w_grant = r_ptr + SEL_W'(k);
            end
        end
    end

    // One-hot accept to the winner; forced low while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && w_xfer) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    // Priority pointer and burst counter advance only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_xfer) begin
            if (w_next_cnt == 4'(BURST)) begin
                r_ptr <= w_grant + SEL_W'(1);
                r_cnt <= '0;
            end else begin
                r_ptr <= w_grant;
                r_cnt <= w_next_cnt;
            end
        end
    end

    // Output register: load the winner, or drain when nobody requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.req_data[w_grant];
                r_out_sel   <= w_grant;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: a BURST=4 and a BURST=1 instance see identical
// stimulus and are compared against a transaction-level reference model.
module tb_mux_rr_sched;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mux_rr_sched_if b4 ();
    mux_rr_sched_if b1 ();

    mux_rr_sched #(.BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_rr_sched #(.BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state, index 0 -> BURST=4, index 1 -> BURST=1
    int       burst [2] = '{4, 1};
    int       m_ptr [2] = '{0, 0};
    int       m_cnt [2] = '{0, 0};
    bit       m_ov  [2] = '{0, 0};
    int       m_os  [2] = '{0, 0};
    bit [7:0] m_od  [2] = '{0, 0};

    logic [7:0] cur_v = '0;
    logic       cur_r = 1'b0;
    logic [7:0] rd [8];

    function automatic int grant(int p, logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [19:0] expv(int j);
        logic [7:0] rr;
        int g;
        rr = '0;
        g  = grant(m_ptr[j], cur_v);
        if (rst_n && (!m_ov[j] || cur_r) && g >= 0) rr[g] = 1'b1;
        return {rr, m_ov[j], 3'(m_os[j]), m_od[j]};
    endfunction

    function automatic logic [19:0] obs(int j);
        if (j == 0) return {b4.req_ready, b4.out_valid, b4.out_sel, b4.out_data};
        return {b1.req_ready, b1.out_valid, b1.out_sel, b1.out_data};
    endfunction

    task automatic set_in(input logic [7:0] v, input logic r);
        cur_v = v;
        cur_r = r;
        b4.req_valid = v;  b1.req_valid = v;
        b4.out_ready = r;  b1.out_ready = r;
        for (int i = 0; i < 8; i++) begin
            b4.req_data[i] = rd[i];
            b1.req_data[i] = rd[i];
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_ptr[j] = 0; m_cnt[j] = 0; m_ov[j] = 0; m_os[j] = 0; m_od[j] = '0;
        end
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        int g, n;
        bit ld;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            for (int j = 0; j < 2; j++) begin
                ld = !m_ov[j] || cur_r;
                g  = grant(m_ptr[j], cur_v);
                if (ld && g >= 0) begin
                    m_ov[j] = 1; m_os[j] = g; m_od[j] = rd[g];
                    n = ((g == m_ptr[j]) ? m_cnt[j] : 0) + 1;
                    if (n == burst[j]) begin
                        m_ptr[j] = (g + 1) % 8; m_cnt[j] = 0;
                    end else begin
                        m_ptr[j] = g; m_cnt[j] = n;
                    end
                end else if (ld) begin
                    m_ov[j] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) rd[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(8'h00, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            rand_data();
            set_in(8'($urandom), 1'($urandom));
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== 20'h0) begin
                    n_fail++;
                    $display("FAIL reset_hold[%0d] got %h exp %h", j, obs(j), 20'h0);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_in(8'h00, 1'($urandom));
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== 20'h0) begin
                    n_fail++;
                    $display("FAIL reset_idle[%0d] got %h exp %h", j, obs(j), 20'h0);
                end
            end
            tick();
        end
    endtask

    task automatic test_burst_rr();
        logic [11:0] e4;
        logic [2:0]  e1;
        for (int i = 0; i < 8; i++) rd[i] = 8'h10 + 8'(i);
        for (int c = 0; c < 34; c++) begin
            set_in(8'hFF, 1'b1);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== expv(j)) begin
                    n_fail++;
                    $display("FAIL burst_model[%0d] c=%0d got %h exp %h", j, c, obs(j), expv(j));
                end
            end
            tick();
            e4 = {1'b1, 3'((c / 4) % 8), 8'h10 + 8'((c / 4) % 8)};
            e1 = 3'(c % 8);
            n_tests++;
            if ({b4.out_valid, b4.out_sel, b4.out_data} !== e4) begin
                n_fail++;
                $display("FAIL burst_seq4 c=%0d got %h exp %h", c, {b4.out_valid, b4.out_sel, b4.out_data}, e4);
            end
            n_tests++;
            if (b1.out_sel !== e1 || b1.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_seq1 c=%0d got sel %0d exp %0d", c, b1.out_sel, e1);
            end
        end
    endtask

    task automatic test_rotation();
        int exp_seq [6] = '{0, 2, 7, 0, 2, 7};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            rand_data();
            set_in(8'b1000_0101, 1'b1);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== expv(j)) begin
                    n_fail++;
                    $display("FAIL rot_model[%0d] c=%0d got %h exp %h", j, c, obs(j), expv(j));
                end
            end
            tick();
            n_tests++;
            if (b1.out_sel !== 3'(exp_seq[c]) || b1.out_data !== rd[exp_seq[c]]) begin
                n_fail++;
                $display("FAIL rot_seq c=%0d got sel %0d exp %0d", c, b1.out_sel, exp_seq[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_seq [4] = '{3, 3, 3, 4};
        do_reset();
        rand_data();
        rd[3] = 8'hA5;
        set_in(8'h08, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            rand_data();
            rd[3] = 8'hA5;
            set_in(8'hFF, 1'b0);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== {8'h00, 1'b1, 3'd3, 8'hA5}) begin
                    n_fail++;
                    $display("FAIL bp_stall[%0d] c=%0d got %h exp %h", j, c, obs(j), {8'h00, 1'b1, 3'd3, 8'hA5});
                end
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            rand_data();
            set_in(8'hFF, 1'b1);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== expv(j)) begin
                    n_fail++;
                    $display("FAIL bp_model[%0d] c=%0d got %h exp %h", j, c, obs(j), expv(j));
                end
            end
            tick();
            n_tests++;
            if (b4.out_valid !== 1'b1 || b4.out_sel !== 3'(exp_seq[c])) begin
                n_fail++;
                $display("FAIL bp_resume c=%0d got v%0b sel %0d exp sel %0d", c, b4.out_valid, b4.out_sel, exp_seq[c]);
            end
        end
    endtask

    task automatic test_dropout();
        logic [7:0] vs [7] = '{8'h60, 8'h60, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        int exp_seq [7] = '{5, 5, 6, 6, 6, 6, 7};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            rand_data();
            set_in(vs[c], 1'b1);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== expv(j)) begin
                    n_fail++;
                    $display("FAIL drop_model[%0d] c=%0d got %h exp %h", j, c, obs(j), expv(j));
                end
            end
            tick();
            n_tests++;
            if (b4.out_sel !== 3'(exp_seq[c])) begin
                n_fail++;
                $display("FAIL drop_seq c=%0d got sel %0d exp %0d", c, b4.out_sel, exp_seq[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int c = 0; c < 400; c++) begin
            rand_data();
            v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            set_in(v, ($urandom_range(0, 9) < 7));
            #1;
            for (int j = 0; j < 2; j++) begin
                n_tests++;
                if (obs(j) !== expv(j)) begin
                    n_fail++;
                    $display("FAIL rand_model[%0d] c=%0d got %h exp %h", j, c, obs(j), expv(j));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        int low;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            rand_data();
            set_in(8'($urandom_range(1, 255)), 1'b1);
            tick();
        end
        rand_data();
        set_in(8'($urandom_range(1, 255)), 1'b1);
        #3 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if (obs(j) !== 20'h0) begin
                n_fail++;
                $display("FAIL async_rst[%0d] got %h exp %h", j, obs(j), 20'h0);
            end
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        v = 8'($urandom_range(1, 255)) & 8'hFE;
        if (v == 8'h00) v = 8'h40;
        low = 0;
        for (int i = 7; i >= 0; i--) if (v[i]) low = i;
        rand_data();
        set_in(v, 1'b1);
        #1;
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if (obs(j) !== expv(j) || obs(j)[19:12] !== (8'h01 << low)) begin
                n_fail++;
                $display("FAIL post_rst_ready[%0d] got %h exp %h", j, obs(j), expv(j));
            end
        end
        tick();
        n_tests++;
        if (b4.out_sel !== 3'(low) || b1.out_sel !== 3'(low) || b4.out_data !== rd[low]) begin
            n_fail++;
            $display("FAIL post_rst_grant got sel %0d/%0d exp %0d", b4.out_sel, b1.out_sel, low);
        end
    endtask

    initial begin
        test_reset();
        test_burst_rr();
        test_rotation();
        test_backpressure();
        test_dropout();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
